// File: rtl/acc_deshifter.sv
// -----------------------------------------------------------------------------
// acc_deshifter
//
// Collects a bit-serial accumulator stream (LSB first) into 32-bit words and
// writes each completed word to a single-port SRAM at consecutive addresses,
// starting from a base latched when the transfer is armed. A transfer writes
// (img_size + 1) words, and the address wraps modulo the SRAM depth.
//
// Ports
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset; aborts any transfer
//   sram_en       one-cycle enable/write strobe per completed word
//   sram_addr     SRAM write address, valid while sram_en = 1
//   sram_data     SRAM write data, valid while sram_en = 1
//   shift_start   one-cycle pulse; arms a transfer when idle
//   shift_idle    1 = idle and ready, 0 = transfer in progress
//   start_addr    base address, sampled on an accepted shift_start
//   img_size      word count minus 1, sampled on an accepted shift_start
//   serial_input  serial data bit
//   serial_en     qualifies serial_input while a transfer is in progress
// -----------------------------------------------------------------------------
module acc_deshifter #(
   parameter int SRAM_DEPTH = 1024,
   localparam int AW = $clog2(SRAM_DEPTH)
) (
   input  logic          clk,
   input  logic          reset_n,
   output logic          sram_en,
   output logic [AW-1:0] sram_addr,
   output logic [31:0]   sram_data,
   input  logic          shift_start,
   output logic          shift_idle,
   input  logic [AW-1:0] start_addr,
   input  logic [AW-1:0] img_size,
   input  logic          serial_input,
   input  logic          serial_en
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LAST  = 2'd2
   } state_t;

   state_t        state_q,     state_d;
   logic [AW-1:0] base_q,      base_d;
   logic [AW-1:0] last_q,      last_d;
   logic [AW-1:0] word_idx_q,  word_idx_d;
   logic [4:0]    bit_cnt_q,   bit_cnt_d;
   logic [31:0]   shreg_q,     shreg_d;
   logic          sram_en_q,   sram_en_d;
   logic [AW-1:0] sram_addr_q, sram_addr_d;
   logic [31:0]   sram_data_q, sram_data_d;

   logic [31:0]   shreg_next;

   // New bit enters at the MSB so that after 32 shifts the first bit
   // received sits in bit 0.
   assign shreg_next = {serial_input, shreg_q[31:1]};

   always_comb begin
      // NOTE: every variable gets its hold value first so that no path
      // through the case/if tree leaves one unassigned and infers a latch.
      state_d     = state_q;
      base_d      = base_q;
      last_d      = last_q;
      word_idx_d  = word_idx_q;
      bit_cnt_d   = bit_cnt_q;
      shreg_d     = shreg_q;
      sram_en_d   = 1'b0;
      sram_addr_d = sram_addr_q;
      sram_data_d = sram_data_q;

      unique case (state_q)
         IDLE: begin
            // serial_en is deliberately ignored here: stray bits before the
            // start pulse must not shift the word alignment.
            if (shift_start) begin
               base_d     = start_addr;
               last_d     = img_size;
               word_idx_d = '0;
               bit_cnt_d  = '0;
               shreg_d    = '0;
               state_d    = SHIFT;
            end
         end

         SHIFT: begin
            if (serial_en) begin
               shreg_d   = shreg_next;
               bit_cnt_d = bit_cnt_q + 5'd1;
               if (bit_cnt_q == 5'd31) begin
                  sram_en_d   = 1'b1;
                  sram_data_d = shreg_next;
                  sram_addr_d = base_q + word_idx_q;
                  word_idx_d  = word_idx_q + AW'(1);
                  // Compare before the increment so img_size = 2^AW-1
                  // still terminates after 2^AW words.
                  if (word_idx_q == last_q) begin
                     state_d = LAST;
                  end
               end
            end
         end

         LAST: begin
            // The final write pulse is on the outputs during this cycle.
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         base_q      <= '0;
         last_q      <= '0;
         word_idx_q  <= '0;
         bit_cnt_q   <= '0;
         shreg_q     <= '0;
         sram_en_q   <= 1'b0;
         sram_addr_q <= '0;
         sram_data_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // computed from the previous cycle, independent of statement order.
         state_q     <= state_d;
         base_q      <= base_d;
         last_q      <= last_d;
         word_idx_q  <= word_idx_d;
         bit_cnt_q   <= bit_cnt_d;
         shreg_q     <= shreg_d;
         sram_en_q   <= sram_en_d;
         sram_addr_q <= sram_addr_d;
         sram_data_q <= sram_data_d;
      end
   end

   assign sram_en    = sram_en_q;
   assign sram_addr  = sram_addr_q;
   assign sram_data  = sram_data_q;
   assign shift_idle = (state_q == IDLE);

endmodule

// File: tb/tb_acc_deshifter.sv
// -----------------------------------------------------------------------------
// tb_acc_deshifter
//
// Self-checking bench for acc_deshifter. Table-driven transfers plus a few
// hand-written sequences (busy start, reset abort, pre-start bits). Every
// expected SRAM write is pushed to a scoreboard queue when its last serial bit
// is driven and popped by a monitor when the DUT pulses sram_en.
// -----------------------------------------------------------------------------
module tb_acc_deshifter;

   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          sram_en;
   logic [AW-1:0] sram_addr;
   logic [31:0]   sram_data;
   logic          shift_start;
   logic          shift_idle;
   logic [AW-1:0] start_addr;
   logic [AW-1:0] img_size;
   logic          serial_input;
   logic          serial_en;

   acc_deshifter #(.SRAM_DEPTH(1024)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .sram_en      (sram_en),
      .sram_addr    (sram_addr),
      .sram_data    (sram_data),
      .shift_start  (shift_start),
      .shift_idle   (shift_idle),
      .start_addr   (start_addr),
      .img_size     (img_size),
      .serial_input (serial_input),
      .serial_en    (serial_en)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } exp_t;

   typedef struct {
      logic [AW-1:0]    start;
      logic [AW-1:0]    size;
      logic [9:0][31:0] data;
      bit               gaps;
   } xfer_t;

   exp_t exp_q[$];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   // Scoreboard monitor: every write pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (reset_n === 1'b1 && sram_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", 32'(sram_addr), 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("sram_addr", 32'(sram_addr), 32'(e.addr));
            check("sram_data", sram_data, e.data);
         end
      end
   end

   task automatic do_start(input logic [AW-1:0] sa, input logic [AW-1:0] sz);
      @(negedge clk);
      shift_start = 1'b1;
      start_addr  = sa;
      img_size    = sz;
      @(posedge clk);
      #1;
      check("idle_drop_on_start", 32'(shift_idle), 32'd0);
      shift_start = 1'b0;
   endtask

   // Sends one word LSB first; optional random serial_en gaps. The expected
   // write is pushed as the 32nd bit is driven and the pulse must be visible
   // right after the edge that samples it.
   task automatic send_word(input logic [31:0] w, input logic [AW-1:0] addr, input bit gaps);
      exp_t e;
      for (int i = 0; i < 32; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
               @(negedge clk);
               serial_en    = 1'b0;
               serial_input = 1'($urandom);
            end
         end
         @(negedge clk);
         serial_en    = 1'b1;
         serial_input = w[i];
         if (i == 31) begin
            check("no_early_pulse", 32'(sram_en), 32'd0);
            e.addr = addr;
            e.data = w;
            exp_q.push_back(e);
         end
         @(posedge clk);
         #1;
         if (i == 31) check("pulse_latency", 32'(sram_en), 32'd1);
      end
   endtask

   // Called right after the final word's pulse edge.
   task automatic finish_xfer(input string tag);
      check({tag, "_busy_during_last"}, 32'(shift_idle), 32'd0);
      @(posedge clk);
      #1;
      check({tag, "_idle_after"}, 32'(shift_idle), 32'd1);
      check({tag, "_en_low_after"}, 32'(sram_en), 32'd0);
      check({tag, "_scoreboard_empty"}, 32'(exp_q.size()), 32'd0);
      serial_en = 1'b0;
   endtask

   task automatic run_xfer(input xfer_t x, input string tag);
      do_start(x.start, x.size);
      for (int w = 0; w <= int'(x.size); w++) begin
         send_word(x.data[w], x.start + AW'(w), x.gaps);
      end
      finish_xfer(tag);
   endtask

   xfer_t tbl[3];

   initial begin
      // Transfer table: back-to-back count, address wrap, gapped single word.
      tbl[0].start = 10'd0;
      tbl[0].size  = 10'd9;
      tbl[0].gaps  = 1'b0;
      for (int i = 0; i < 10; i++) tbl[0].data[i] = 32'(i);

      tbl[1].start = 10'd1020;
      tbl[1].size  = 10'd5;
      tbl[1].gaps  = 1'b0;
      tbl[1].data  = '0;
      tbl[1].data[0] = 32'hA5A5_5A5A;
      tbl[1].data[1] = 32'hFFFF_FFFF;
      tbl[1].data[2] = 32'h8000_0001;
      tbl[1].data[3] = 32'h0000_0000;
      tbl[1].data[4] = 32'h1234_5678;
      tbl[1].data[5] = 32'h8765_4321;

      tbl[2].start = 10'd33;
      tbl[2].size  = 10'd0;
      tbl[2].gaps  = 1'b1;
      tbl[2].data  = '0;
      tbl[2].data[0] = 32'hDEAD_BEEF;

      reset_n      = 1'b0;
      shift_start  = 1'b0;
      start_addr   = '0;
      img_size     = '0;
      serial_input = 1'b0;
      serial_en    = 1'b0;
      #23;
      check("rst_idle", 32'(shift_idle), 32'd1);
      check("rst_en",   32'(sram_en),    32'd0);
      check("rst_addr", 32'(sram_addr),  32'd0);
      check("rst_data", sram_data,       32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int t = 0; t < 3; t++) begin
         run_xfer(tbl[t], $sformatf("xfer%0d", t));
         if (t == 0) begin
            repeat (500) @(posedge clk);
            #1;
            check("quiet_500_idle", 32'(shift_idle), 32'd1);
         end
      end
      check("hold_addr", 32'(sram_addr), 32'd33);
      check("hold_data", sram_data, 32'hDEAD_BEEF);

      // One-word transfer with a second start pulse arriving mid-word.
      do_start(10'd200, 10'd0);
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         serial_en    = 1'b1;
         serial_input = 1'(32'h1234_5678 >> i);
         shift_start  = (i == 10);
         start_addr   = (i == 10) ? 10'd700 : 10'd200;
         img_size     = (i == 10) ? 10'd3   : 10'd0;
         if (i == 31) begin
            exp_q.push_back('{addr: 10'd200, data: 32'h1234_5678});
         end
         @(posedge clk);
      end
      shift_start = 1'b0;
      #1;
      check("busy_start_pulse", 32'(sram_en), 32'd1);
      finish_xfer("busy_start");

      // Reset after 40 bits of a 3-word transfer: only word 0 is written.
      do_start(10'd300, 10'd2);
      send_word(32'h0F0F_0F0F, 10'd300, 1'b0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         serial_en    = 1'b1;
         serial_input = 1'b1;
      end
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("abort_en",   32'(sram_en),    32'd0);
      check("abort_idle", 32'(shift_idle), 32'd1);
      check("abort_sb",   32'(exp_q.size()), 32'd0);
      @(negedge clk);
      reset_n   = 1'b1;
      serial_en = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      check("abort_no_resume_idle", 32'(shift_idle), 32'd1);
      tbl[2].start   = 10'd500;
      tbl[2].gaps    = 1'b0;
      tbl[2].data[0] = 32'hCAFE_F00D;
      run_xfer(tbl[2], "post_reset");

      // Qualified bits while idle must not leak into the first word.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         serial_en    = 1'b1;
         serial_input = 1'b1;
      end
      tbl[2].start   = 10'd7;
      tbl[2].data[0] = 32'h0000_0003;
      run_xfer(tbl[2], "prestart");

      repeat (50) @(posedge clk);
      check("final_sb_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/acc_deshifter.md
Name: acc_deshifter

Overview:
- Serial-to-parallel deshifter for accumulator results.
- Collects a bit-serial stream, LSB first, into 32-bit words.
- Writes each completed word to a single-port SRAM at consecutive addresses, starting from a programmable base.
- Sits between the serial accumulator array and the output/activation SRAM; a start pulse arms a transfer of (img_size+1) words.

Parameters:
- SRAM_DEPTH, 1024, number of SRAM words. Localparam AW = ceil(log2(SRAM_DEPTH)), 10 by default, is the address/size width.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- sram_en  output  1  SRAM enable and write strobe, one-cycle pulse per completed word.
- sram_addr  output  AW  SRAM write address, valid while sram_en=1.
- sram_data  output  32  SRAM write data, valid while sram_en=1.
- shift_start  input  1  one-cycle pulse; starts a transfer when idle.
- shift_idle  output  1  1 = idle and ready; 0 = transfer in progress.
- start_addr  input  AW  base address; sampled on an accepted shift_start.
- img_size  input  AW  word count minus 1; sampled on an accepted shift_start.
- serial_input  input  1  serial data bit.
- serial_en  input  1  qualifies serial_input; a bit is captured on each rising edge with serial_en=1 while busy.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, shift_idle=1, sram_en=0, sram_addr=0, sram_data=0.
  - Bit counter, word counter and shift register cleared.
  - Reset mid-transfer aborts it immediately; no further writes.
- FSM states: IDLE, SHIFT, LAST.
- IDLE:
  - shift_start=1 at a rising edge latches base=start_addr and last=img_size, clears both counters, enters SHIFT.
  - shift_idle drops to 0 on that same edge.
  - serial_en is ignored in IDLE.
- SHIFT:
  - On each edge with serial_en=1: shreg <= {serial_input, shreg[31:1]} (first bit received = bit 0); bit counter increments mod 32.
  - serial_en=0 pauses capture with no loss of state; bits may arrive back-to-back across word boundaries with no gap.
  - On the edge capturing bit 31 of a word:
    - register sram_data = assembled word (including that bit), sram_addr = base + word_idx (mod 2^AW), sram_en=1 for exactly one cycle;
    - word_idx increments.
  - If the completed word was word number `last`, the same edge moves to LAST.
- LAST:
  - One cycle with the final sram_en pulse asserted.
  - Next edge: state=IDLE, shift_idle=1, sram_en=0.
- Latency: a word's 32nd serial bit sampled at edge N gives sram_en=1 from edge N to edge N+1.
- Outputs while not pulsing: sram_data and sram_addr hold their last written values; sram_en=0.
- shift_start while busy (SHIFT or LAST) is ignored; start_addr and img_size changes mid-transfer have no effect.
- img_size=0 gives a one-word transfer. img_size=2^AW−1 gives 2^AW words, with the address wrapping.
- Exactly (img_size+1) write pulses per transfer; nothing is written outside a transfer.
- Fully synchronous apart from reset; no combinational input-to-output paths.

Test Plan:
- start_addr=0, img_size=9; stream words 0..9 back-to-back LSB first with serial_en held high → 10 pulses, addrs 0..9, data 0x0..0x9 in order; shift_idle returns to 1 one cycle after the 10th pulse; no extra pulses in the following 500 cycles.
- start_addr=1020, img_size=5, data 0xA5A55A5A, 0xFFFFFFFF, 0x80000001, … → addresses 1020,1021,1022,1023,0,1 (wrap); data bit-exact.
- Pattern 0xDEADBEEF with serial_en deasserted for random gaps mid-word → single pulse with 0xDEADBEEF; pulse occurs exactly one cycle after the 32nd qualified bit.
- img_size=0 with a single word 0x12345678 → one pulse at start_addr; second shift_start during the transfer ignored; shift_idle high afterwards.
- reset_n low after 40 bits of a 3-word transfer → sram_en=0 and shift_idle=1 immediately; only word 0 written; a new transfer after reset completes normally from its start_addr.
- Serial bits with serial_en=1 while idle, then shift_start → the pre-start bits are ignored; first word contains only bits received after start.
